hdr_capture_multi: RTL and testbench
====================================

Name: hdr_capture_multi

Overview:
- Parametrised successor to the byte-wide MAC RX header capture path: accepts a multi-byte-per-beat MAC RX stream with per-lane byte enables.
- Captures the first HDR_BYTES bytes of each packet into a flat header buffer and discards the remainder.
- Presents header, lengths and flags to the parser/TCAM stage through a valid/ready handshake.
- Sits between the MAC RX FIFO and the header parser in pipe_top.

Parameters:
- BEAT_BYTES, 4, bytes per input beat (1..16).
- HDR_BYTES, 192, header buffer depth in bytes (must be ≥ BEAT_BYTES).
- LEN_W, 16, width of length fields.
- PAD_BYTE, 8'h00, fill value for unwritten header bytes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- s_valid  in  1  input beat valid.
- s_data  in  BEAT_BYTES*8  beat data; lane 0 = s_data[7:0] is the earliest byte.
- s_keep  in  BEAT_BYTES  lane enables; contiguous from lane 0.
- s_last  in  1  final beat of packet.
- s_ready  out  1  input ready.
- hdr_valid  out  1  header record valid.
- hdr_ready  in  1  downstream accept.
- hdr_flat  out  HDR_BYTES*8  packet byte i at [i*8 +: 8].
- hdr_len  out  LEN_W  bytes captured = min(pkt_len, HDR_BYTES).
- pkt_len  out  LEN_W  total packet bytes, saturating.
- hdr_trunc  out  1  pkt_len > HDR_BYTES.
- len_sat  out  1  packet byte count saturated.
- keep_err  out  1  non-contiguous s_keep seen in this packet.
- pkt_cnt  out  32  headers delivered (hdr_valid && hdr_ready), wrapping.

Behaviour:
- Reset (rst_n=1, async): state CAPTURE; s_ready=0 while rst_n is high, 1 after release; hdr_valid=0; hdr_flat all PAD_BYTE; hdr_len, pkt_len, pkt_cnt, and all flags = 0.
- Reset mid-packet: partial packet is discarded entirely; the first beat after release starts a new packet at byte 0.
- States:
  - CAPTURE: accepting beats; byte_ptr < HDR_BYTES.
  - SKIP: header full; beats accepted and dropped, only counted.
  - HOLD: record presented; s_ready=0.
- s_ready = (state != HOLD), combinational from state only. A beat is accepted when s_valid && s_ready.
- Lane counting:
  - Valid lanes = leading ones of s_keep.
  - Lanes after the first zero are ignored and set keep_err for the packet.
  - A non-last beat with partial keep is legal: only the kept lanes are counted, with no gap in byte_ptr.
- Writes:
  - Kept lane j is written to header byte byte_ptr+j if byte_ptr+j < HDR_BYTES; otherwise it is dropped.
  - byte_ptr += kept lanes.
  - When byte_ptr reaches ≥ HDR_BYTES without s_last, move to SKIP.
- pkt_len accumulates kept lanes and saturates at 2^LEN_W−1, setting len_sat.
- Accepted beat with s_last (from CAPTURE or SKIP):
  - Next cycle: HOLD with hdr_valid=1 and all record fields final. Latency is 1 cycle from the last-beat handshake.
  - A last beat with s_keep=0 is legal; a packet of zero total bytes emits pkt_len=0, hdr_len=0.
- HOLD:
  - Record outputs are stable while hdr_valid && !hdr_ready.
  - On hdr_ready: hdr_valid=0 next cycle, pkt_cnt+1, state CAPTURE, header buffer refilled with PAD_BYTE, and byte_ptr, pkt_len and flags cleared.
  - The first beat of the next packet can be accepted the cycle after the handshake, giving 1 bubble cycle between packets.
- s_valid low mid-packet: state and pointers hold, with no timeout.
- s_data, s_keep and s_last are don't-care when s_valid=0.

Test Plan:
- BEAT_BYTES=4, HDR_BYTES=192: 64-byte IPv4/TCP packet (16 beats), hdr_ready=1 → hdr_valid one cycle after the last beat; pkt_len=64, hdr_len=64, hdr_trunc=0; byte 23=0x06, bytes 64..191=0x00; pkt_cnt=1.
- 300-byte UDP packet → pkt_len=300, hdr_len=192, hdr_trunc=1; byte 191 equals input byte 191; SKIP beats fully accepted with s_ready=1.
- 62-byte packet whose last beat has s_keep=4'b0011 → pkt_len=62; bytes 60,61 written; byte 62=PAD_BYTE. Separately, s_keep=4'b0101 on a beat → keep_err=1 and only lane 0 counted.
- hdr_ready held low 10 cycles with the next packet already offered → s_ready=0 throughout HOLD, hdr_flat stable; the second packet is captured intact after release with exactly 1 bubble cycle.
- rst_n pulsed high after 20 bytes of a packet → all outputs at reset values; the following 64-byte packet yields pkt_len=64 with no residue.
- HDR_BYTES=190, BEAT_BYTES=4, 200-byte packet → beat 47 writes lanes 0-1 only; hdr_len=190, hdr_trunc=1. With LEN_W=8, a 300-byte packet → pkt_len=255, len_sat=1.

Source files
------------

// File: rtl/hdr_capture_multi.sv
// Captures the first HDR_BYTES bytes of each multi-byte-per-beat MAC RX packet and
// presents the header, lengths and error flags to the parser through a valid/ready hold.
module hdr_capture_multi #(
  parameter int         BEAT_BYTES = 4,
  parameter int         HDR_BYTES  = 192,
  parameter int         LEN_W      = 16,
  parameter logic [7:0] PAD_BYTE   = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  input  logic [BEAT_BYTES*8-1:0] s_data,
  input  logic [BEAT_BYTES-1:0]   s_keep,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    hdr_valid,
  input  logic                    hdr_ready,
  output logic [HDR_BYTES*8-1:0]  hdr_flat,
  output logic [LEN_W-1:0]        hdr_len,
  output logic [LEN_W-1:0]        pkt_len,
  output logic                    hdr_trunc,
  output logic                    len_sat,
  output logic                    keep_err,
  output logic [31:0]             pkt_cnt
);
  localparam int PTR_W  = $clog2(HDR_BYTES + 2*BEAT_BYTES + 1);
  localparam int LANE_W = $clog2(BEAT_BYTES + 1);

  typedef enum logic [1:0] {CAPTURE, SKIP, HOLD} state_t;

  state_t              state;
  logic [PTR_W-1:0]    byte_ptr;
  logic [PTR_W-1:0]    next_ptr;
  logic [LANE_W-1:0]   lanes;
  logic                keep_gap;
  logic [LEN_W:0]      len_next;
  logic                accept;

  function automatic logic [LANE_W-1:0] lead_ones(input logic [BEAT_BYTES-1:0] keep);
    logic [LANE_W-1:0] n;
    logic              run;
    n   = '0;
    run = 1'b1;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      run = run & keep[j];
      if (run) n = n + LANE_W'(1);
    end
    return n;
  endfunction

  // Returns {saturated, value}; the accumulator sticks at its all-ones maximum.
  function automatic logic [LEN_W:0] sat_add(input logic [LEN_W-1:0] acc,
                                             input logic [LANE_W-1:0] n);
    logic [LEN_W:0] sum;
    sum = {1'b0, acc} + (LEN_W+1)'(n);
    if (sum[LEN_W]) return {1'b1, {LEN_W{1'b1}}};
    return sum;
  endfunction

  always_comb begin
    lanes    = lead_ones(s_keep);
    keep_gap = (s_keep >> lanes) != '0;
    next_ptr = byte_ptr + PTR_W'(lanes);
    len_next = sat_add(pkt_len, lanes);
  end

  assign accept  = s_valid && s_ready;
  assign s_ready = !rst_n && (state != HOLD);
  assign hdr_len = (byte_ptr >= PTR_W'(HDR_BYTES)) ? LEN_W'(HDR_BYTES) : LEN_W'(byte_ptr);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= CAPTURE;
      byte_ptr  <= '0;
      hdr_valid <= 1'b0;
      hdr_flat  <= {HDR_BYTES{PAD_BYTE}};
      pkt_len   <= '0;
      hdr_trunc <= 1'b0;
      len_sat   <= 1'b0;
      keep_err  <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      case (state)
        CAPTURE, SKIP: begin
          if (accept) begin
            // Lanes landing at or past HDR_BYTES are dropped; SKIP only counts.
            if (state == CAPTURE) begin
              for (int i = 0; i < HDR_BYTES; i++) begin
                for (int j = 0; j < BEAT_BYTES; j++) begin
                  if (LANE_W'(j) < lanes && int'(byte_ptr) + j == i)
                    hdr_flat[i*8 +: 8] <= s_data[j*8 +: 8];
                end
              end
              byte_ptr <= next_ptr;
            end
            pkt_len <= len_next[LEN_W-1:0];
            if (len_next[LEN_W])                   len_sat   <= 1'b1;
            if (keep_gap)                          keep_err  <= 1'b1;
            if (next_ptr > PTR_W'(HDR_BYTES))      hdr_trunc <= 1'b1;
            if (s_last) begin
              state     <= HOLD;
              hdr_valid <= 1'b1;
            end else if (next_ptr >= PTR_W'(HDR_BYTES)) begin
              state <= SKIP;
            end
          end
        end
        HOLD: begin
          if (hdr_ready) begin
            state     <= CAPTURE;
            hdr_valid <= 1'b0;
            pkt_cnt   <= pkt_cnt + 32'd1;
            hdr_flat  <= {HDR_BYTES{PAD_BYTE}};
            byte_ptr  <= '0;
            pkt_len   <= '0;
            hdr_trunc <= 1'b0;
            len_sat   <= 1'b0;
            keep_err  <= 1'b0;
          end
        end
        default: state <= CAPTURE;
      endcase
    end
  end
endmodule

// File: tb/tb_hdr_capture_multi.sv
// Bench for hdr_capture_multi: two instances (192-byte/16-bit and 190-byte/8-bit) share
// one stimulus stream and are checked against a byte-queue reference model.
module tb_hdr_capture_multi;
  localparam int HA = 192, LA = 16, HB = 190, LB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic s_valid = 1'b0, s_last = 1'b0, hdr_ready = 1'b0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_keep = '0;

  logic a_s_ready, a_hdr_valid, a_trunc, a_sat, a_kerr;
  logic [HA*8-1:0] a_flat;
  logic [LA-1:0] a_hlen, a_plen;
  logic [31:0] a_cnt;
  logic b_s_ready, b_hdr_valid, b_trunc, b_sat, b_kerr;
  logic [HB*8-1:0] b_flat;
  logic [LB-1:0] b_hlen, b_plen;
  logic [31:0] b_cnt;

  always #5 clk = ~clk;

  hdr_capture_multi #(.BEAT_BYTES(4), .HDR_BYTES(HA), .LEN_W(LA), .PAD_BYTE(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep),
    .s_last(s_last), .s_ready(a_s_ready), .hdr_valid(a_hdr_valid), .hdr_ready(hdr_ready),
    .hdr_flat(a_flat), .hdr_len(a_hlen), .pkt_len(a_plen), .hdr_trunc(a_trunc),
    .len_sat(a_sat), .keep_err(a_kerr), .pkt_cnt(a_cnt));

  hdr_capture_multi #(.BEAT_BYTES(4), .HDR_BYTES(HB), .LEN_W(LB), .PAD_BYTE(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep),
    .s_last(s_last), .s_ready(b_s_ready), .hdr_valid(b_hdr_valid), .hdr_ready(hdr_ready),
    .hdr_flat(b_flat), .hdr_len(b_hlen), .pkt_len(b_plen), .hdr_trunc(b_trunc),
    .len_sat(b_sat), .keep_err(b_kerr), .pkt_cnt(b_cnt));

  int errors = 0, checks = 0, exp_cnt = 0;
  logic [31:0] pk_data[$];
  logic [3:0]  pk_keep[$];
  logic [7:0]  m_bytes[$];
  bit          m_err;

  typedef struct {
    int n;
    int plen_a; int hlen_a; bit tr_a;
    int plen_b; int hlen_b; bit tr_b; bit sat_b;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_pkt(input int n);
    int rem;
    pk_data.delete();
    pk_keep.delete();
    rem = n;
    do begin
      pk_data.push_back($urandom);
      pk_keep.push_back(rem >= 4 ? 4'hF : 4'((1 << rem) - 1));
      rem = rem - 4;
    end while (rem > 0);
  endtask

  // Reference: packet bytes are the leading kept lanes of every beat, in order.
  task automatic build_model();
    int n;
    m_bytes.delete();
    m_err = 0;
    foreach (pk_data[k]) begin
      n = 0;
      while (n < 4 && pk_keep[k][n]) n++;
      if ((pk_keep[k] >> n) != 4'h0) m_err = 1;
      for (int j = 0; j < n; j++) m_bytes.push_back(pk_data[k][j*8 +: 8]);
    end
  endtask

  task automatic check_rec(input string tag, input int H, input int LW,
                           input logic [HA*8-1:0] flat, input logic [15:0] plen,
                           input logic [15:0] hlen, input logic tr, input logic sat,
                           input logic kerr);
    int cnt, mx, bad;
    logic [7:0] e;
    build_model();
    cnt = m_bytes.size();
    mx  = (1 << LW) - 1;
    chk({tag, ".pkt_len"}, plen, cnt > mx ? mx : cnt);
    chk({tag, ".hdr_len"}, hlen, cnt < H ? cnt : H);
    chk({tag, ".hdr_trunc"}, tr, cnt > H);
    chk({tag, ".len_sat"}, sat, cnt > mx);
    chk({tag, ".keep_err"}, kerr, m_err);
    bad = -1;
    e = 8'h00;
    for (int i = 0; i < H; i++) begin
      e = (i < cnt) ? m_bytes[i] : 8'h00;
      if (flat[i*8 +: 8] !== e) begin bad = i; break; end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s.hdr_flat byte %0d: got %02h expected %02h", tag, bad, flat[bad*8 +: 8], e);
    end
  endtask

  task automatic check_both();
    check_rec("a", HA, LA, a_flat, a_plen, a_hlen, a_trunc, a_sat, a_kerr);
    check_rec("b", HB, LB, {16'h0, b_flat}, {8'h0, b_plen}, {8'h0, b_hlen}, b_trunc, b_sat, b_kerr);
  endtask

  task automatic send_pkt(input int gap_max, input int nbeats);
    int t, lim;
    lim = (nbeats < 0) ? pk_data.size() : nbeats;
    for (int k = 0; k < lim; k++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = $urandom;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = pk_data[k];
      s_keep  = pk_keep[k];
      s_last  = (k == pk_data.size() - 1);
      t = 0;
      while (!a_s_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) chk("s_ready_timeout", 0, 1);
      @(posedge clk);
    end
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called at the negedge after the last beat: record must already be presented.
  task automatic finish_pkt(input int delay);
    chk("hdr_valid_latency_a", a_hdr_valid, 1);
    chk("hdr_valid_latency_b", b_hdr_valid, 1);
    chk("s_ready_in_hold", a_s_ready, 0);
    check_both();
    if (delay > 0) begin
      repeat (delay) @(negedge clk);
      chk("hdr_valid_held", a_hdr_valid, 1);
      check_both();
    end
    hdr_ready = 1'b1;
    @(negedge clk);
    hdr_ready = 1'b0;
    exp_cnt++;
    chk("hdr_valid_drop", a_hdr_valid, 0);
    chk("pkt_cnt_a", a_cnt, exp_cnt);
    chk("pkt_cnt_b", b_cnt, exp_cnt);
    chk("flat_refill", a_flat, '0);
    chk("pkt_len_clear", a_plen, 0);
  endtask

  task automatic check_reset_values();
    chk("rst.s_ready", a_s_ready, 0);
    chk("rst.hdr_valid", a_hdr_valid, 0);
    chk("rst.flat_a", a_flat, '0);
    chk("rst.flat_b", b_flat, '0);
    chk("rst.lens", {a_plen, a_hlen, b_plen, b_hlen}, 0);
    chk("rst.flags", {a_trunc, a_sat, a_kerr, b_trunc, b_sat, b_kerr}, 0);
    chk("rst.pkt_cnt", {a_cnt, b_cnt}, 0);
  endtask

  logic [HA*8-1:0] snap;

  initial begin
    vecs = '{
      '{64,  64,  64,  0, 64,  64,  0, 0},
      '{300, 300, 192, 1, 255, 190, 1, 1},
      '{62,  62,  62,  0, 62,  62,  0, 0},
      '{200, 200, 192, 1, 200, 190, 1, 0},
      '{0,   0,   0,   0, 0,   0,   0, 0},
      '{192, 192, 192, 0, 192, 190, 1, 0},
      '{190, 190, 190, 0, 190, 190, 0, 0}
    };
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b0;
    @(negedge clk);
    chk("s_ready_after_release", a_s_ready, 1);

    // Table-driven packets with spec-derived constants plus the model.
    for (int v = 0; v < 7; v++) begin
      build_pkt(vecs[v].n);
      if (vecs[v].n > 23) pk_data[5][31:24] = 8'h06;
      send_pkt(0, -1);
      @(negedge clk);
      chk($sformatf("vec%0d.plen_a", v), a_plen, vecs[v].plen_a);
      chk($sformatf("vec%0d.hlen_a", v), a_hlen, vecs[v].hlen_a);
      chk($sformatf("vec%0d.tr_a", v), a_trunc, vecs[v].tr_a);
      chk($sformatf("vec%0d.plen_b", v), b_plen, vecs[v].plen_b);
      chk($sformatf("vec%0d.hlen_b", v), b_hlen, vecs[v].hlen_b);
      chk($sformatf("vec%0d.tr_b", v), b_trunc, vecs[v].tr_b);
      chk($sformatf("vec%0d.sat_b", v), b_sat, vecs[v].sat_b);
      if (v == 0) begin
        chk("ipv4.proto_byte23", a_flat[23*8 +: 8], 8'h06);
        chk("ipv4.pad_byte64", a_flat[64*8 +: 8], 8'h00);
      end
      if (v == 1) chk("udp.byte191", a_flat[191*8 +: 8], pk_data[47][31:24]);
      if (v == 2) begin
        chk("short.byte61", a_flat[61*8 +: 8], pk_data[15][15:8]);
        chk("short.byte62_pad", a_flat[62*8 +: 8], 8'h00);
      end
      if (v == 3) chk("h190.byte189", b_flat[189*8 +: 8], pk_data[47][15:8]);
      finish_pkt(0);
    end

    // Non-contiguous keep mid-packet: only lane 0 counts.
    build_pkt(12);
    pk_keep[1] = 4'b0101;
    send_pkt(0, -1);
    @(negedge clk);
    chk("gap.pkt_len", a_plen, 9);
    chk("gap.keep_err", a_kerr, 1);
    chk("gap.byte4", a_flat[4*8 +: 8], pk_data[1][7:0]);
    chk("gap.byte5", a_flat[5*8 +: 8], pk_data[2][7:0]);
    finish_pkt(0);

    // Backpressure for 10 cycles with the next packet already offered.
    build_pkt(40);
    send_pkt(0, -1);
    @(negedge clk);
    check_both();
    snap = a_flat;
    build_pkt(64);
    fork
      send_pkt(0, -1);
      begin
        repeat (10) begin
          @(negedge clk);
          chk("hold.s_ready", a_s_ready, 0);
          chk("hold.flat_stable", a_flat, snap);
        end
        hdr_ready = 1'b1;
        @(posedge clk);
        #1;
        hdr_ready = 1'b0;
        exp_cnt++;
        chk("hold.release_valid", a_hdr_valid, 0);
        chk("hold.bubble_ready", a_s_ready, 1);
        chk("hold.first_beat_offered", s_valid, 1);
      end
    join
    @(negedge clk);
    finish_pkt(0);

    // Reset after 20 bytes of a packet, then a clean 64-byte packet.
    build_pkt(64);
    send_pkt(0, 5);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_cnt = 0;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b0;
    build_pkt(64);
    send_pkt(0, -1);
    @(negedge clk);
    chk("post_rst.pkt_len", a_plen, 64);
    finish_pkt(1);

    // Randomized packets, gaps, keeps and downstream delays.
    for (int r = 0; r < 30; r++) begin
      build_pkt($urandom_range(320, 0));
      foreach (pk_keep[k])
        if ($urandom_range(7, 0) == 0) pk_keep[k] = 4'($urandom);
      send_pkt(2, -1);
      @(negedge clk);
      finish_pkt($urandom_range(3, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
